bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble): inverse of Binary_to_BCD.
//  Turns operator-entered decimal digits (switch/button entry) into a binary value for
//  the velocity/counter datapath. Uses the same i_Start / o_DV handshake as Binary_to_BCD.
//  Processes one bit per shift/adjust pair, so it needs no wide combinational divider.
// PARAMETERS
//  DECIMAL_DIGITS  4   number of BCD nibbles on i_BCD
//  OUTPUT_WIDTH    14  binary result width; must satisfy 2^W > 10^D-1 (14 for D=4)
// PORTS
//  i_Clock   in   1       single clock, all logic on rising edge
//  i_Reset   in   1       asynchronous, active-high reset
//  i_BCD     in   4*D     packed digits, [3:0] = units, [4D-1:4D-4] = most significant
//  i_Start   in   1       request; sampled only in IDLE
//  o_Binary  out  W       result; held stable between o_DV pulses
//  o_DV      out  1       one-cycle pulse: o_Binary/o_Error valid
//  o_Busy    out  1       high from accepted start until the o_DV cycle inclusive
//  o_Error   out  1       set with o_DV if any input nibble > 9; held until next o_DV
// BEHAVIOUR
//  - Reset (async): state IDLE, counter 0, work reg 0, o_Binary=0, o_DV=0, o_Busy=0, o_Error=0.
//  - Work register {bcd[4D-1:0], bin[W-1:0]}; bit counter ceil(log2(W+1)) wide.
//  - FSM: IDLE, SHIFT, ADJUST, DONE.
//    IDLE: o_Busy=0. With i_Start=1: latch i_BCD into bcd, clear bin, counter=0, o_Busy<=1.
//          If any nibble >9, go to DONE with the error flag set. Otherwise go to SHIFT.
//    SHIFT: shift the whole work register right by 1, counter+1, go to ADJUST.
//    ADJUST: subtract 3 from every bcd nibble that is >= 8 (all nibbles in parallel).
//          If counter==W go to DONE, else go to SHIFT.
//    DONE: o_Binary<=bin (or 0 on error), o_Error<=flag, o_DV<=1 for exactly this one
//          cycle, go to IDLE. o_Busy stays high through the o_DV cycle and drops after it.
//  - Latency: o_DV is high during the cycle after edge 2W+1, counted from the edge that
//    sampled i_Start (the start edge is edge 0). That is 29 clocks for W=14. The error
//    path takes 1 clock.
//  - Start throughput: one conversion per 2W+2 clocks. i_Start is ignored in SHIFT,
//    ADJUST and DONE; it is never queued. A start held high across DONE is accepted on
//    the next IDLE cycle, so a held start gives back-to-back conversions.
//  - o_DV is never high for two consecutive cycles. o_Binary/o_Error change only on the
//    edge that raises o_DV.
//  - Width: if W is undersized, the result is value mod 2^W with no flag. The
//    PARAMETERS rule forbids this configuration.
//  - Reset mid-operation: abort immediately and return to the reset values; no o_DV.
//  - i_BCD is sampled only at start; later changes do not affect a conversion in flight.
// STRUCTURE
//  - Shared include bcd_defs.vh holds: BCD_MAX_DIGIT=9, BCD_ADJ_THRESHOLD=8,
//    BCD_ADJ_VALUE=3, and the FSM state encodings (2-bit). Binary_to_BCD uses the same file.
//  - One sub-module, bcd_digit_adjust: combinational 4-bit in/out, out = (in>=8) ? in-3 : in.
//    Instantiated DECIMAL_DIGITS times via generate. All other logic stays in this module.
// TESTING
//  1. i_BCD=16'h0000, start pulse -> o_DV at clock 29, o_Binary=0, o_Error=0.
//  2. i_BCD=16'h9999 -> o_Binary=14'd9999 (0x270F) at clock 29; o_Busy high from clock 1
//     through clock 29.
//  3. i_BCD=16'h0888, then 16'h0889 back-to-back with start held -> 888 then 889; the
//     two o_DV pulses are 30 clocks apart.
//  4. i_BCD=16'h12A4 -> o_DV at clock 2, o_Error=1, o_Binary=0. Next valid conversion
//     clears o_Error.
//  5. Start pulses at clocks 5 and 20 during conversion -> ignored; exactly one o_DV.
//     Changing i_BCD mid-run does not alter the result.
//  6. Assert i_Reset at clock 10 of a conversion -> all outputs 0 asynchronously; no o_DV.
//     A new start after release converts correctly.

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and FSM encoding for the BCD/binary converters.
// The digit limits and the 2-bit state codes live here so both converter directions agree.
package bcd_to_binary_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT     = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd8;
  localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ADJUST = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/valid handshake bundle between an operator-entry front end and the converter.
// The master drives the packed digits and start; the slave returns the result and status.
interface bcd_to_binary_if #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 14
);

  logic [4*DECIMAL_DIGITS-1:0] i_BCD;
  logic                        i_Start;
  logic [OUTPUT_WIDTH-1:0]     o_Binary;
  logic                        o_DV;
  logic                        o_Busy;
  logic                        o_Error;

  modport master (
    output i_BCD,
    output i_Start,
    input  o_Binary,
    input  o_DV,
    input  o_Busy,
    input  o_Error
  );

  modport slave (
    input  i_BCD,
    input  i_Start,
    output o_Binary,
    output o_DV,
    output o_Busy,
    output o_Error
  );

endinterface

// File: rtl/bcd_to_binary_digit_adjust.sv
// Per-nibble correction step of reverse double-dabble: a digit that picked up a
// halved tens bit (value >= 8 after the shift) is pulled back by 3.
module bcd_to_binary_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESHOLD) ? (digit_i - BCD_ADJ_VALUE) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter: shifts the digit register right into the binary
// register one bit at a time, correcting every nibble after each shift.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 14
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  bcd_to_binary_if.slave    bus
);

  localparam int BCD_W = 4 * DECIMAL_DIGITS;
  localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(OUTPUT_WIDTH);

  state_t                  state_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [BCD_W-1:0]        bcdAdj_d;
  logic [OUTPUT_WIDTH-1:0] bin_q;
  logic [OUTPUT_WIDTH-1:0] binary_q;
  logic [CNT_W-1:0]        count_q;
  logic                    errFlag_q;
  logic                    dv_q;
  logic                    busy_q;
  logic                    error_q;
  logic                    startInvalid_d;

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adjust
    bcd_to_binary_digit_adjust u_adjust (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcdAdj_d[4*g +: 4])
    );
  end

  always_comb begin
    startInvalid_d = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (digit_invalid(bus.i_BCD[4*i +: 4])) begin
        startInvalid_d = 1'b1;
      end
    end
  end

  // Busy is set on the accepting edge and cleared only by an idle cycle without a start,
  // so a held start keeps it high across back-to-back conversions.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      errFlag_q <= 1'b0;
      binary_q  <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_Start) begin
            bcd_q     <= bus.i_BCD;
            bin_q     <= '0;
            count_q   <= '0;
            errFlag_q <= startInvalid_d;
            busy_q    <= 1'b1;
            state_q   <= startInvalid_d ? ST_DONE : ST_SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          bin_q   <= {bcd_q[0], bin_q[OUTPUT_WIDTH-1:1]};
          bcd_q   <= {1'b0, bcd_q[BCD_W-1:1]};
          count_q <= count_q + CNT_W'(1);
          state_q <= ST_ADJUST;
        end
        ST_ADJUST: begin
          bcd_q   <= bcdAdj_d;
          state_q <= (count_q == LAST_COUNT) ? ST_DONE : ST_SHIFT;
        end
        ST_DONE: begin
          binary_q <= errFlag_q ? '0 : bin_q;
          error_q  <= errFlag_q;
          dv_q     <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Binary = binary_q;
  assign bus.o_DV     = dv_q;
  assign bus.o_Busy   = busy_q;
  assign bus.o_Error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed-vector bench for bcd_to_binary: conversion results, latency, handshake,
// error reporting, start rejection while busy and asynchronous reset abort.
module tb_bcd_to_binary;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;
  localparam int LAT    = 2 * WIDTH + 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   edgeCount;

  bcd_to_binary_if #(.DECIMAL_DIGITS(DIGITS), .OUTPUT_WIDTH(WIDTH)) bus ();

  bcd_to_binary #(.DECIMAL_DIGITS(DIGITS), .OUTPUT_WIDTH(WIDTH)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edgeCount = 0;
  always @(posedge clk) edgeCount = edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bcd, input logic start);
    @(negedge clk);
    bus.i_BCD   = bcd;
    bus.i_Start = start;
  endtask

  // Waits (bounded) at negedges for o_DV and returns the edge index that raised it.
  task automatic waitDv(input string tag, output int at);
    int n;
    n = 0;
    while (!bus.o_DV && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, {31'd0, bus.o_DV}, 32'd1);
    at = edgeCount;
  endtask

  task automatic runConversion(input string tag, input logic [15:0] bcd,
                               input logic [13:0] expBin, input logic expErr, input int expLat);
    int n;
    int busyLow;
    applyStimulus(bcd, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.i_Start = 1'b0;
    n = 0;
    busyLow = 0;
    while (!bus.o_DV && n < 100) begin
      if (!bus.o_Busy) busyLow++;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, n, expLat);
    checkOutput({tag, "_binary"}, {18'd0, bus.o_Binary}, {18'd0, expBin});
    checkOutput({tag, "_error"}, {31'd0, bus.o_Error}, {31'd0, expErr});
    checkOutput({tag, "_busy_at_dv"}, {31'd0, bus.o_Busy}, 32'd1);
    checkOutput({tag, "_busy_gaps"}, busyLow, 0);
    @(negedge clk);
    checkOutput({tag, "_dv_pulse"}, {31'd0, bus.o_DV}, 32'd0);
    checkOutput({tag, "_busy_drop"}, {31'd0, bus.o_Busy}, 32'd0);
  endtask

  logic [15:0] vecBcd [6] = '{16'h0000, 16'h9999, 16'h8000, 16'h0010, 16'h1234, 16'h0909};
  logic [13:0] vecBin [6] = '{14'd0, 14'd9999, 14'd8000, 14'd10, 14'd1234, 14'd909};

  initial begin
    int t0, t1, t2;
    int dvCount;
    logic [13:0] got;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.i_BCD   = '0;
    bus.i_Start = 1'b0;

    #1;
    checkOutput("reset_binary", {18'd0, bus.o_Binary}, 32'd0);
    checkOutput("reset_dv", {31'd0, bus.o_DV}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.o_Busy}, 32'd0);
    checkOutput("reset_error", {31'd0, bus.o_Error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runConversion($sformatf("vec%0d", i), vecBcd[i], vecBin[i], 1'b0, LAT);
    end

    runConversion("bad_digit", 16'h12A4, 14'd0, 1'b1, 1);
    repeat (5) @(negedge clk);
    checkOutput("bad_digit_error_held", {31'd0, bus.o_Error}, 32'd1);
    checkOutput("bad_digit_binary_held", {18'd0, bus.o_Binary}, 32'd0);
    runConversion("after_error", 16'h0042, 14'd42, 1'b0, LAT);

    // Start held high across DONE gives two conversions 2W+2 clocks apart.
    applyStimulus(16'h0888, 1'b1);
    @(posedge clk);
    @(negedge clk);
    t0 = edgeCount;
    bus.i_BCD = 16'h0889;
    waitDv("b2b_first", t1);
    checkOutput("b2b_first_binary", {18'd0, bus.o_Binary}, 32'd888);
    checkOutput("b2b_first_latency", t1 - t0, LAT);
    @(negedge clk);
    bus.i_Start = 1'b0;
    checkOutput("b2b_busy_continuous", {31'd0, bus.o_Busy}, 32'd1);
    waitDv("b2b_second", t2);
    checkOutput("b2b_second_binary", {18'd0, bus.o_Binary}, 32'd889);
    checkOutput("b2b_spacing", t2 - t1, 2 * WIDTH + 2);
    repeat (3) @(negedge clk);

    // Starts and digit changes during a conversion must be ignored.
    applyStimulus(16'h4321, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.i_Start = 1'b0;
    dvCount = 0;
    got = '0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.o_DV) begin
        dvCount++;
        got = bus.o_Binary;
      end
      bus.i_Start = (i == 5 || i == 20);
      if (i == 5) bus.i_BCD = 16'h9999;
      @(negedge clk);
    end
    bus.i_Start = 1'b0;
    checkOutput("ignore_start_dv_count", dvCount, 1);
    checkOutput("ignore_start_binary", {18'd0, got}, 32'd4321);

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(16'h0777, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.i_Start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midrun_busy_before_reset", {31'd0, bus.o_Busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", {31'd0, bus.o_Busy}, 32'd0);
    checkOutput("async_reset_binary", {18'd0, bus.o_Binary}, 32'd0);
    checkOutput("async_reset_dv", {31'd0, bus.o_DV}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dvCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_DV) dvCount++;
      @(negedge clk);
    end
    checkOutput("reset_abort_no_dv", dvCount, 0);
    runConversion("after_reset", 16'h0457, 14'd457, 1'b0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
